// File: rtl/period_meter_if.sv
// Reference / delay-stage signal bundle for period_meter.
// The slave side is the meter; the master side supplies ref_in and delay_pct.
interface period_meter_if;
   logic        ref_in;
   logic [7:0]  delay_pct;
   logic [7:0]  count_quater_period;
   logic [31:0] period_count;
   logic        valid;
   logic        busy;
   logic        timeout;
   logic        overrun;

   modport master (
      output ref_in, delay_pct,
      input  count_quater_period, period_count, valid, busy, timeout, overrun
   );

   modport slave (
      input  ref_in, delay_pct,
      output count_quater_period, period_count, valid, busy, timeout, overrun
   );
endinterface

// File: rtl/period_meter.sv
// Measures the reference period in sclock cycles and scales it by delay_pct
// into the 8-bit tick count used by the quarter-period delay stage.
//
// state   | meaning
// IDLE    | no period in progress, waiting for the first reference edge
// MEASURE | counting sclock cycles since the last accepted edge
// CALC    | product + 40-step divide running; meas_q says whether cnt is also measuring
module period_meter #(
   parameter int unsigned TICK_DIV   = 10000,
   parameter int unsigned MIN_PERIOD = 1000,
   parameter int unsigned MAX_PERIOD = 100_000_000
) (
   input  logic          sclock,
   input  logic          resetn,
   period_meter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      CALC    = 2'd2
   } state_t;

   localparam logic [31:0] DIVISOR   = 32'(100 * TICK_DIV);
   localparam logic [31:0] MIN_CNT   = 32'(MIN_PERIOD);
   localparam logic [31:0] MAX_CNT   = 32'(MAX_PERIOD);
   localparam logic [5:0]  CALC_LAST = 6'd40;

   state_t      state_q, state_d;
   logic        meas_q, meas_d;

   logic        sync_1, sync_2, sync_2_d, edge_q;
   logic [31:0] cnt_q;
   logic [31:0] period_q;
   logic [6:0]  pct_q;
   logic [5:0]  calc_step_q;
   logic [39:0] dvd_q;
   logic [31:0] rem_q;
   logic [7:0]  cqp_q;
   logic        valid_q;
   logic        ovr_q;

   logic        edge_ok, cnt_max, calc_last;
   logic        cnt_restart, cnt_run, latch_period, tmo_pulse, ovr_set;
   logic [38:0] prod;
   logic [32:0] r_sh;
   logic        q_bit;
   logic [31:0] rem_next;
   logic [39:0] quot;

   assign edge_ok   = edge_q && (cnt_q >= MIN_CNT);
   assign cnt_max   = (cnt_q == MAX_CNT);
   assign calc_last = (state_q == CALC) && (calc_step_q == CALC_LAST);

   always_ff @(posedge sclock or negedge resetn) begin
      if (!resetn) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         sync_2_d <= 1'b0;
         edge_q   <= 1'b0;
      end else begin
         sync_1   <= bus.ref_in;
         sync_2   <= sync_1;
         sync_2_d <= sync_2;
         edge_q   <= sync_2 & ~sync_2_d;
      end
   end

   always_ff @(posedge sclock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         meas_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         meas_q  <= meas_d;
      end
   end

   always_comb begin
      state_d = state_q;
      meas_d  = meas_q;
      case (state_q)
         IDLE: begin
            if (edge_q) state_d = MEASURE;
         end
         MEASURE: begin
            if (edge_ok) begin
               state_d = CALC;
               meas_d  = 1'b1;
            end else if (cnt_max) begin
               state_d = IDLE;
            end
         end
         CALC: begin
            // a timeout mid-CALC stops measuring but lets the divide finish
            if (meas_q && !edge_ok && cnt_max) meas_d = 1'b0;
            if (calc_last) state_d = meas_d ? MEASURE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_restart  = 1'b0;
      cnt_run      = 1'b0;
      latch_period = 1'b0;
      tmo_pulse    = 1'b0;
      ovr_set      = 1'b0;
      case (state_q)
         IDLE: cnt_restart = edge_q;
         MEASURE: begin
            cnt_run = 1'b1;
            if (edge_ok) begin
               cnt_restart  = 1'b1;
               latch_period = 1'b1;
            end else if (cnt_max) begin
               tmo_pulse = 1'b1;
            end
         end
         CALC: begin
            if (meas_q) begin
               cnt_run = 1'b1;
               if (edge_ok) begin
                  cnt_restart = 1'b1;
                  ovr_set     = 1'b1;
               end else if (cnt_max) begin
                  tmo_pulse = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // pct_q never exceeds 100, so the product fits in 39 bits
   assign prod     = 39'(period_q) * 39'(pct_q);
   assign r_sh     = {rem_q, dvd_q[39]};
   assign q_bit    = (r_sh >= {1'b0, DIVISOR});
   assign rem_next = q_bit ? 32'(r_sh - {1'b0, DIVISOR}) : r_sh[31:0];
   assign quot     = {dvd_q[38:0], q_bit};

   always_ff @(posedge sclock or negedge resetn) begin
      if (!resetn) begin
         cnt_q       <= '0;
         period_q    <= '0;
         pct_q       <= '0;
         calc_step_q <= '0;
         dvd_q       <= '0;
         rem_q       <= '0;
         cqp_q       <= '0;
         valid_q     <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         valid_q <= 1'b0;

         if (cnt_restart)  cnt_q <= 32'd1;
         else if (cnt_run) cnt_q <= cnt_q + 32'd1;

         if (latch_period) begin
            period_q <= cnt_q;
            pct_q    <= (bus.delay_pct > 8'd100) ? 7'd100 : bus.delay_pct[6:0];
         end

         if (ovr_set) ovr_q <= 1'b1;

         if (state_q == CALC) begin
            calc_step_q <= calc_step_q + 6'd1;
            if (calc_step_q == 6'd0) begin
               dvd_q <= {1'b0, prod};
               rem_q <= '0;
            end else begin
               // restoring divide: dividend shifts out the top, quotient bits in the bottom
               dvd_q <= quot;
               rem_q <= rem_next;
            end
            if (calc_last) begin
               cqp_q   <= (quot[39:8] != '0) ? 8'd255 : quot[7:0];
               valid_q <= 1'b1;
            end
         end else begin
            calc_step_q <= '0;
         end
      end
   end

   assign bus.count_quater_period = cqp_q;
   assign bus.period_count        = period_q;
   assign bus.valid               = valid_q;
   assign bus.busy                = (state_q == CALC);
   assign bus.timeout             = tmo_pulse;
   assign bus.overrun             = ovr_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with scaled-down parameters
// (TICK_DIV=10 so the divisor is 1000, MIN_PERIOD=20, MAX_PERIOD=5000).
module tb_period_meter;

   localparam int unsigned TD   = 10;
   localparam int unsigned MINP = 20;
   localparam int unsigned MAXP = 5000;

   logic sclock = 1'b0;
   logic resetn = 1'b0;

   period_meter_if bus();

   period_meter #(.TICK_DIV(TD), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)) dut (
      .sclock (sclock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 sclock = ~sclock;

   // One row = one reference period of n cycles ending (optionally) in a rising
   // edge; the expectations describe what is seen during those n cycles.
   typedef struct {
      int n;
      int pct;
      bit rise;
      bit glitch;
      int vc;
      int vidx;
      int vpc;
      int vcqp;
      int bc;
      int tc;
      int tidx;
      bit ovr;
      int pc_end;
      int cqp_end;
   } row_t;

   row_t rows[22];

   int checks   = 0;
   int failures = 0;
   bit last_rise = 1'b0;

   int m_vc, m_vidx, m_vpc, m_vcqp, m_bc, m_tc, m_tidx;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Sample #1 after each rising edge, then drive ref_in for the next cycle.
   task automatic run_period(input int n, input int pct, input bit rise, input bit glitch);
      m_vc = 0; m_vidx = -1; m_vpc = -1; m_vcqp = -1;
      m_bc = 0; m_tc = 0; m_tidx = -1;
      for (int i = 1; i <= n; i++) begin
         @(posedge sclock);
         #1;
         if (bus.valid) begin
            m_vc++;
            if (m_vidx < 0) begin
               m_vidx = i;
               m_vpc  = int'(bus.period_count);
               m_vcqp = int'(bus.count_quater_period);
            end
         end
         if (bus.timeout) begin
            m_tc++;
            if (m_tidx < 0) m_tidx = i;
         end
         if (bus.busy) m_bc++;
         if (i == 10) bus.delay_pct = 8'(pct);
         if (i == n && rise)
            bus.ref_in = 1'b1;
         else if (glitch)
            bus.ref_in = last_rise && ((i < 5) || (i >= 10 && i < 15));
         else
            bus.ref_in = last_rise && (i < n / 2);
      end
      last_rise = rise;
   endtask

   task automatic check_row(input int r);
      run_period(rows[r].n, rows[r].pct, rows[r].rise, rows[r].glitch);
      chk($sformatf("r%0d_valid_count", r), m_vc, rows[r].vc);
      if (rows[r].vc != 0) begin
         chk($sformatf("r%0d_valid_cycle", r), m_vidx, rows[r].vidx);
         chk($sformatf("r%0d_period_at_valid", r), m_vpc, rows[r].vpc);
         chk($sformatf("r%0d_cqp_at_valid", r), m_vcqp, rows[r].vcqp);
      end
      chk($sformatf("r%0d_busy_cycles", r), m_bc, rows[r].bc);
      chk($sformatf("r%0d_timeout_count", r), m_tc, rows[r].tc);
      if (rows[r].tc != 0)
         chk($sformatf("r%0d_timeout_cycle", r), m_tidx, rows[r].tidx);
      chk($sformatf("r%0d_overrun", r), bus.overrun, rows[r].ovr);
      chk($sformatf("r%0d_period_hold", r), bus.period_count, rows[r].pc_end);
      chk($sformatf("r%0d_cqp_hold", r), bus.count_quater_period, rows[r].cqp_end);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_cqp"},     bus.count_quater_period, 0);
      chk({tag, "_period"},  bus.period_count, 0);
      chk({tag, "_valid"},   bus.valid, 0);
      chk({tag, "_busy"},    bus.busy, 0);
      chk({tag, "_timeout"}, bus.timeout, 0);
      chk({tag, "_overrun"}, bus.overrun, 0);
   endtask

   initial begin
      //          n     pct  rs gl  vc vidx  vpc   vcqp  bc  tc tidx  ov  pc_end cqp_end
      rows[0]  = '{300,  100, 1, 0, 0, 0,    0,    0,    0,  0, 0,    0,  0,    0};
      rows[1]  = '{2504, 100, 1, 0, 0, 0,    0,    0,    0,  0, 0,    0,  0,    0};
      rows[2]  = '{2490, 50,  1, 0, 1, 45,   2504, 250,  41, 0, 0,    0,  2504, 250};
      rows[3]  = '{2490, 25,  1, 0, 1, 45,   2490, 124,  41, 0, 0,    0,  2490, 124};
      rows[4]  = '{2490, 150, 1, 0, 1, 45,   2490, 62,   41, 0, 0,    0,  2490, 62};
      rows[5]  = '{3000, 100, 1, 0, 1, 45,   2490, 249,  41, 0, 0,    0,  2490, 249};
      rows[6]  = '{2000, 0,   1, 0, 1, 45,   3000, 255,  41, 0, 0,    0,  3000, 255};
      rows[7]  = '{1234, 101, 1, 0, 1, 45,   2000, 0,    41, 0, 0,    0,  2000, 0};
      rows[8]  = '{500,  100, 1, 0, 1, 45,   1234, 123,  41, 0, 0,    0,  1234, 123};
      rows[9]  = '{100,  7,   1, 0, 1, 45,   500,  50,   41, 0, 0,    0,  500,  50};
      rows[10] = '{2504, 100, 1, 1, 1, 45,   100,  0,    41, 0, 0,    0,  100,  0};
      rows[11] = '{200,  100, 1, 0, 1, 45,   2504, 250,  41, 0, 0,    0,  2504, 250};
      rows[12] = '{5100, 100, 0, 0, 1, 45,   200,  20,   41, 1, 5003, 0,  200,  20};
      rows[13] = '{300,  100, 1, 0, 0, 0,    0,    0,    0,  0, 0,    0,  200,  20};
      rows[14] = '{800,  100, 1, 0, 0, 0,    0,    0,    0,  0, 0,    0,  200,  20};
      rows[15] = '{1000, 100, 1, 0, 1, 45,   800,  80,   41, 0, 0,    0,  800,  80};
      rows[16] = '{30,   100, 1, 0, 0, 0,    0,    0,    27, 0, 0,    0,  1000, 80};
      rows[17] = '{600,  100, 1, 0, 1, 15,   1000, 100,  14, 0, 0,    1,  1000, 100};
      rows[18] = '{200,  100, 1, 0, 1, 45,   600,  60,   41, 0, 0,    1,  600,  60};
      rows[19] = '{100,  100, 1, 0, 0, 0,    0,    0,    0,  0, 0,    0,  0,    0};
      rows[20] = '{700,  100, 1, 0, 0, 0,    0,    0,    0,  0, 0,    0,  0,    0};
      rows[21] = '{100,  100, 0, 0, 1, 45,   700,  70,   41, 0, 0,    0,  700,  70};

      bus.ref_in    = 1'b0;
      bus.delay_pct = 8'd100;
      resetn        = 1'b0;
      repeat (3) @(posedge sclock);
      #1;
      check_zero("reset");
      resetn = 1'b1;

      for (int r = 0; r <= 18; r++) check_row(r);

      // Row 18 ended with an accepted edge: CALC is running. Reset at E+20.
      for (int i = 1; i <= 23; i++) begin
         @(posedge sclock);
         #1;
         bus.ref_in = (i < 10);
      end
      chk("midcalc_busy_before_reset", bus.busy, 1);
      resetn = 1'b0;
      #1;
      check_zero("midcalc_reset");
      repeat (3) @(posedge sclock);
      #1;
      resetn    = 1'b1;
      last_rise = 1'b0;

      for (int r = 19; r <= 21; r++) check_row(r);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period of the external reference waveform in `sclock` cycles and converts it to the 8-bit tick count consumed by the quarter-period delay stage directly downstream. The conversion scales the measured period by a user delay percentage. A fresh value plus a one-cycle valid strobe is produced for every accepted period. Sits between the reference input pin and the delay/trigger stage; the C server supplies `delay_pct`.

## Interface

- `TICK_DIV`, 10000: `sclock` cycles per output tick (1..2^24-1).
- `MIN_PERIOD`, 1000: shortest accepted period in cycles; closer edges are glitches.
- `MAX_PERIOD`, 100_000_000: period timeout in cycles (< 2^32).
- `sclock` in 1: system clock, all logic on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ref_in` in 1: asynchronous reference waveform.
- `delay_pct` in 8: delay percentage; values >100 clamp to 100.
- `count_quater_period` out 8: scaled tick count to the delay stage.
- `period_count` out 32: last accepted period in cycles.
- `valid` out 1: one-cycle pulse when both outputs update.
- `busy` out 1: high while CALC is active.
- `timeout` out 1: one-cycle pulse on period timeout.
- `overrun` out 1: sticky; a period completed while CALC was busy.

## Operation

- `ref_in` passes through a 2-FF synchronizer and then an edge register. `edge` = synced rising edge, a 1-cycle pulse.
- A 32-bit `cnt` increments every cycle in MEASURE.
- FSM states: IDLE, MEASURE, CALC.
  - IDLE: wait for `edge`. On `edge`: `cnt`<=1, go to MEASURE.
  - MEASURE, `edge` with `cnt` < MIN_PERIOD: ignored. `cnt` keeps counting.
  - MEASURE, `edge` with `cnt` >= MIN_PERIOD: latch `period_count`<=`cnt`. Latch clamped `delay_pct`. Restart `cnt`<=1. Start CALC. The counter keeps measuring the next period during CALC; the FSM records "measuring" in a sub-flag and returns to MEASURE after CALC.
  - MEASURE, `cnt` == MAX_PERIOD with no accepted edge: pulse `timeout`, go to IDLE. Outputs hold their last values.
- CALC arithmetic:
  - Product P = `period_count` × pct is a 39-bit unsigned value, registered in 1 cycle.
  - P is then divided by the constant D = 100×TICK_DIV (D < 2^31) with a 40-iteration restoring divider, one bit per cycle, quotient Q up to 39 bits.
  - `count_quater_period` = Q > 255 ? 255 : Q[7:0].
  - pct = 0 gives 0.
  - Truncating division, no rounding.
- An accepted edge that arrives while CALC is busy: that period is discarded, `overrun`<=1, and counting restarts (`cnt`<=1). The in-flight CALC completes normally.
- A timeout during CALC still completes the CALC. The FSM then enters IDLE.
- Reset in any state, including mid-CALC: all state clears and no `valid` is emitted.

## Timing

- Reset values: `count_quater_period`=0, `period_count`=0, `valid`=0, `busy`=0, `timeout`=0, `overrun`=0. FSM is IDLE; synchronizer and `cnt` are 0.
- `ref_in` rise to `edge`: 3 cycles (2 sync + edge register).
- Let E be the cycle `edge` is high and accepted.
  - `period_count` and latched pct are valid at E+1.
  - `busy` is high from E+1 through E+41.
  - `count_quater_period` updates and `valid`=1 at E+42, exactly one cycle wide.
- `period_count` = number of `sclock` cycles between consecutive accepted `edge` pulses. This equals the true period in cycles, with synchronizer quantization of ±1.
- `timeout` pulses in the cycle `cnt` reaches MAX_PERIOD.
- `delay_pct` is sampled only at E. Changes at other times take effect on the next period.

## Test plan

- Defaults; square wave with period 250399 cycles, pct=100 -> `period_count`=250399, `count_quater_period`=25, `valid` exactly at E+42, one cycle wide.
- Period 249147, pct=50, then pct=25 -> outputs 12, then 6. pct=150 -> 24 (clamped to 100).
- Glitch: a 20-cycle pulse 500 cycles after an accepted edge, true period 250399 -> glitch ignored; `period_count`=250399, output 25.
- Stop `ref_in` after one period -> `timeout` pulses once MAX_PERIOD cycles after the last edge; FSM in IDLE; outputs hold 25; two later edges 250399 apart -> normal update.
- TICK_DIV=100, MIN_PERIOD=10, period 50000, pct=100 -> Q=500, output saturates to 255. Edges 30 cycles apart during CALC -> `overrun`=1 (sticky).
- Assert `resetn`=0 at E+20 mid-CALC -> all outputs 0 immediately; no `valid`; measurement resumes from IDLE after release.
